dctlb_fwd_buf: RTL
==================

# dctlb_fwd_buf

Decoupling buffer between the dctlb forward ports and the L1 dcache request pipes. It queues translated load (fwd0) and store (fwd1) requests in two independent in-order FIFOs, so that dcache back-pressure does not stall the TLB. It also applies L1 TLB invalidation commands to any queued entry whose hpaddr is being removed, marking it stale before it reaches the dcache. Each port has its own FIFO, and an invalidation counter is exported for performance monitoring.

## Interface
- DEPTH, 4: entries per FIFO; power of two, minimum 2.
- CNTW, 8: width of the invalidation counter.

- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- l1tlbtol1_fwd0_valid  in  1  load translation valid
- l1tlbtol1_fwd0_retry  out  1  load FIFO cannot accept
- l1tlbtol1_fwd0  in  I_l1tlbtol1_fwd_type  load translation (coreid, prefetch, l2_prefetch, fault[2:0], hpaddr[10:0], ppaddr[2:0])
- l1tlbtol1_fwd1_valid / _retry / l1tlbtol1_fwd1: the same three signals for the store translation
- l1tlbtol1_cmd_valid  in  1  invalidate command valid
- l1tlbtol1_cmd_retry  out  1  tied 0; a command is always accepted
- l1tlbtol1_cmd  in  I_l1tlbtol1_cmd_type  field hpaddr[10:0] is the entry removed
- fwdbuftol1_ld_valid  out  1  head of the load FIFO valid
- fwdbuftol1_ld_retry  in  1  dcache load pipe busy
- fwdbuftol1_ld  out  I_l1tlbtol1_fwd_type  head of the load FIFO
- fwdbuftol1_st_valid / _retry / fwdbuftol1_st: the same three signals for the store FIFO
- fwdbuf_inval_cnt  out  CNTW  saturating count of entries marked stale

## Operation
- **Handshake:** a transfer occurs when valid=1 and retry=0, on all channels.
  - Valid must not depend combinationally on retry.
  - Retry must not depend combinationally on valid.
- **FIFO storage:** each FIFO is a circular array of DEPTH entries.
  - Read and write pointers are log2(DEPTH) bits wide; an occupancy counter is log2(DEPTH)+1 bits wide.
  - Pointers wrap modulo DEPTH.
- **Input retry:** `*_retry = (occupancy == DEPTH)`, from registered state only.
  - A pop in the same cycle does not lower retry.
- **Output:** `*_valid = (occupancy != 0)` and the payload is the head entry.
  - The head is popped on a transfer.
  - While valid=1 and retry=1, the payload is stable, except that fault may change to 3'b111 (invalidation).
- **Invalidation:** on `cmd_valid`, every occupied entry in both FIFOs with hpaddr == cmd.hpaddr and fault != 3'b111 gets fault set to 3'b111 at the next edge.
  - This includes the entry being enqueued in the same cycle.
  - It also includes the head being popped in the same cycle: the popped copy goes out as presented, and only the enqueue path is patched.
  - fwdbuf_inval_cnt increments by the number of entries newly marked stale, and saturates at 2^CNTW-1.
  - Entries already at 3'b111 are not counted again.
- **Ordering:** the load and store FIFOs are independent; no ordering is kept between them.
- **Reset (reset=0, at any time):** occupancies, pointers and counter go to 0, and every valid and retry output goes low immediately (asynchronous reset). Payload contents are don't-care.

## Timing
- **Latency:** an entry enqueued at edge N is visible at the output in cycle N+1 if its FIFO was empty. There is no same-cycle bypass.
- **Throughput:** 1 entry/cycle/port in steady state while not full.
- **Full boundary:** with occupancy=DEPTH, input retry=1 even if the output pops that cycle. Retry drops the cycle after the occupancy falls.
- **Empty boundary:** push and pop in the same cycle at occupancy 1 leaves occupancy 1.
- **Invalidation timing:** a command in cycle N affects the output payload from cycle N+1.
- **Reset values:**
  - all *_valid = 0, all *_retry = 0 (DEPTH>0, so not full), cmd_retry = 0, fwdbuf_inval_cnt = 0.
  - After reset deasserts, the first push is accepted at the next edge.

## Configuration
- **PREFETCH_DROP_EN not defined:** prefetch entries are treated like any other entry.
- **PREFETCH_DROP_EN defined:** an incoming entry with prefetch=1 arriving while occupancy ≥ DEPTH-1 is accepted and discarded.
  - The channel's retry is forced to 0 for that prefetch entry only.
  - Demand entries (prefetch=0) still see retry = full.
  - Dropped entries are not counted in fwdbuf_inval_cnt.

## Test plan
- **Reset:** after reset, push load hpaddr=0x123 -> fwdbuftol1_ld_valid=1 one cycle later with hpaddr=0x123, fault=0.
- **Fill and back-pressure:** hold ld_retry=1 and push 5 loads (DEPTH=4) -> fwd0_retry=1 after the 4th. Release -> the four entries drain in order, one per cycle, and the 5th is accepted the cycle after occupancy drops.
- **Invalidation of stalled entries:** queue loads with hpaddr 0x010, 0x020, 0x010 and stores with 0x010 while outputs stall, then cmd hpaddr=0x010 -> three entries get fault=3'b111 and fwdbuf_inval_cnt=3. Repeating the cmd leaves the count at 3.
- **Simultaneous enqueue and cmd:** fwd1 push with hpaddr=0x7FF in the same cycle as cmd hpaddr=0x7FF -> that entry leaves with fault=3'b111 and the count increments by 1.
- **Reset mid-operation:** with 3 entries in each FIFO, pulse reset low for one cycle -> both output valids fall immediately, the FIFOs are empty afterwards and the counter reads 0.
- **PREFETCH_DROP_EN:** with occupancy 3, push prefetch=1 -> retry=0, entry discarded, occupancy stays 3. Push prefetch=0 -> accepted, occupancy 4. Without the macro, the prefetch push is enqueued.

Source files
------------

// File: rtl/dctlb_fwd_buf_if.sv
// Shared request/command payload types plus the bundled handshake interface
// between the dctlb forward ports, the invalidation command and the dcache pipes.
package dctlb_fwd_buf_pkg;
  typedef struct packed {
    logic        coreid;
    logic        prefetch;
    logic        l2_prefetch;
    logic [2:0]  fault;
    logic [10:0] hpaddr;
    logic [2:0]  ppaddr;
  } I_l1tlbtol1_fwd_type;

  typedef struct packed {
    logic [10:0] hpaddr;
  } I_l1tlbtol1_cmd_type;
endpackage

interface dctlb_fwd_buf_if #(
  parameter int CNTW = 8
);
  import dctlb_fwd_buf_pkg::*;

  logic                l1tlbtol1_fwd0_valid;
  logic                l1tlbtol1_fwd0_retry;
  I_l1tlbtol1_fwd_type l1tlbtol1_fwd0;
  logic                l1tlbtol1_fwd1_valid;
  logic                l1tlbtol1_fwd1_retry;
  I_l1tlbtol1_fwd_type l1tlbtol1_fwd1;
  logic                l1tlbtol1_cmd_valid;
  logic                l1tlbtol1_cmd_retry;
  I_l1tlbtol1_cmd_type l1tlbtol1_cmd;
  logic                fwdbuftol1_ld_valid;
  logic                fwdbuftol1_ld_retry;
  I_l1tlbtol1_fwd_type fwdbuftol1_ld;
  logic                fwdbuftol1_st_valid;
  logic                fwdbuftol1_st_retry;
  I_l1tlbtol1_fwd_type fwdbuftol1_st;
  logic [CNTW-1:0]     fwdbuf_inval_cnt;

  // master: TLB / dcache side environment; slave: the forward buffer itself
  modport master (
    output l1tlbtol1_fwd0_valid, l1tlbtol1_fwd0, input l1tlbtol1_fwd0_retry,
    output l1tlbtol1_fwd1_valid, l1tlbtol1_fwd1, input l1tlbtol1_fwd1_retry,
    output l1tlbtol1_cmd_valid, l1tlbtol1_cmd, input l1tlbtol1_cmd_retry,
    input fwdbuftol1_ld_valid, fwdbuftol1_ld, output fwdbuftol1_ld_retry,
    input fwdbuftol1_st_valid, fwdbuftol1_st, output fwdbuftol1_st_retry,
    input fwdbuf_inval_cnt
  );

  modport slave (
    input l1tlbtol1_fwd0_valid, l1tlbtol1_fwd0, output l1tlbtol1_fwd0_retry,
    input l1tlbtol1_fwd1_valid, l1tlbtol1_fwd1, output l1tlbtol1_fwd1_retry,
    input l1tlbtol1_cmd_valid, l1tlbtol1_cmd, output l1tlbtol1_cmd_retry,
    output fwdbuftol1_ld_valid, fwdbuftol1_ld, input fwdbuftol1_ld_retry,
    output fwdbuftol1_st_valid, fwdbuftol1_st, input fwdbuftol1_st_retry,
    output fwdbuf_inval_cnt
  );
endinterface

// File: rtl/dctlb_fwd_buf.sv
// Load/store forward buffer: two independent in-order FIFOs with in-place stale marking.
// Optional macro PREFETCH_DROP_EN: prefetches arriving near-full are accepted and discarded.
module dctlb_fwd_fifo
  import dctlb_fwd_buf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int NW    = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_retry,
  input  I_l1tlbtol1_fwd_type in_data,
  output logic                out_valid,
  input  logic                out_retry,
  output I_l1tlbtol1_fwd_type out_data,
  input  logic                cmd_valid,
  input  logic [10:0]         cmd_hpaddr,
  output logic [NW-1:0]       inval_n
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);
`ifdef PREFETCH_DROP_EN
  localparam logic [AW:0] OCC_HIGH = (AW+1)'(DEPTH-1);
`endif
  localparam logic [2:0] STALE = 3'b111;

  I_l1tlbtol1_fwd_type [DEPTH-1:0] mem_q, mem_d;
  I_l1tlbtol1_fwd_type             in_patched;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, off;
  logic [AW:0]   occ_q, occ_d;
  logic          enq, pop, in_hit;

  always_comb begin
`ifdef PREFETCH_DROP_EN
    // a prefetch is never back-pressured; near-full it is swallowed instead of stored
    in_retry = (occ_q == OCC_FULL) && !in_data.prefetch;
    enq      = in_valid && !in_retry && !(in_data.prefetch && (occ_q >= OCC_HIGH));
`else
    in_retry = (occ_q == OCC_FULL);
    enq      = in_valid && !in_retry;
`endif
    pop        = (occ_q != '0) && !out_retry;
    in_hit     = cmd_valid && (in_data.hpaddr == cmd_hpaddr) && (in_data.fault != STALE);
    in_patched = in_data;
    if (in_hit) in_patched.fault = STALE;

    inval_n = '0;
    mem_d   = mem_q;
    off     = '0;
    // slot i is live when its distance from the read pointer is below occupancy
    for (int i = 0; i < DEPTH; i++) begin
      off = AW'(i) - rd_ptr_q;
      if (cmd_valid && ({1'b0, off} < occ_q) && (mem_q[i].hpaddr == cmd_hpaddr) &&
          (mem_q[i].fault != STALE)) begin
        mem_d[i].fault = STALE;
        inval_n        = inval_n + NW'(1);
      end
    end
    if (enq) begin
      mem_d[wr_ptr_q] = in_patched;
      if (in_hit) inval_n = inval_n + NW'(1);
    end

    wr_ptr_d = wr_ptr_q + AW'(enq);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    occ_d    = occ_q + (AW+1)'(enq) - (AW+1)'(pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign out_valid = (occ_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
endmodule

module dctlb_fwd_buf
  import dctlb_fwd_buf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNTW  = 8
) (
  input logic           clk,
  input logic           reset,
  dctlb_fwd_buf_if.slave bus
);
  localparam int NUM_LANES = 2;
  localparam int NW        = $clog2(DEPTH + 2);
  localparam int SW        = CNTW + NW + 1;
  localparam logic [SW-1:0] CNT_MAX = SW'({CNTW{1'b1}});

  // lane 0 carries loads (fwd0 -> ld), lane 1 carries stores (fwd1 -> st)
  logic [NUM_LANES-1:0]               in_valid, in_retry, out_valid, out_retry;
  I_l1tlbtol1_fwd_type [NUM_LANES-1:0] in_data, out_data;
  logic [NUM_LANES-1:0][NW-1:0]        inval_n;
  logic [CNTW-1:0]                     cnt_q, cnt_d;
  logic [SW-1:0]                       cnt_sum;

  assign in_valid  = {bus.l1tlbtol1_fwd1_valid, bus.l1tlbtol1_fwd0_valid};
  assign in_data   = {bus.l1tlbtol1_fwd1, bus.l1tlbtol1_fwd0};
  assign out_retry = {bus.fwdbuftol1_st_retry, bus.fwdbuftol1_ld_retry};

  generate
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      dctlb_fwd_fifo #(
        .DEPTH (DEPTH),
        .NW    (NW)
      ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid[g]),
        .in_retry   (in_retry[g]),
        .in_data    (in_data[g]),
        .out_valid  (out_valid[g]),
        .out_retry  (out_retry[g]),
        .out_data   (out_data[g]),
        .cmd_valid  (bus.l1tlbtol1_cmd_valid),
        .cmd_hpaddr (bus.l1tlbtol1_cmd.hpaddr),
        .inval_n    (inval_n[g])
      );
    end
  endgenerate

  always_comb begin
    cnt_sum = SW'(cnt_q) + SW'(inval_n[0]) + SW'(inval_n[1]);
    cnt_d   = (cnt_sum > CNT_MAX) ? CNT_MAX[CNTW-1:0] : cnt_sum[CNTW-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign bus.l1tlbtol1_fwd0_retry = in_retry[0];
  assign bus.l1tlbtol1_fwd1_retry = in_retry[1];
  assign bus.l1tlbtol1_cmd_retry  = 1'b0;
  assign bus.fwdbuftol1_ld_valid  = out_valid[0];
  assign bus.fwdbuftol1_ld        = out_data[0];
  assign bus.fwdbuftol1_st_valid  = out_valid[1];
  assign bus.fwdbuftol1_st        = out_data[1];
  assign bus.fwdbuf_inval_cnt     = cnt_q;
endmodule
